// File: rtl/wired_alu_exe_pkg.sv
// Shared ALU encodings and the request/result records passed through the execute pipe.
package wired_alu_exe_pkg;

  localparam int ALU_ROB_W = 6;
  localparam int ALU_REG_W = 5;

  localparam logic [1:0] ALU_GTYPE_BW  = 2'd0;
  localparam logic [1:0] ALU_GTYPE_LI  = 2'd1;
  localparam logic [1:0] ALU_GTYPE_INT = 2'd2;
  localparam logic [1:0] ALU_GTYPE_SFT = 2'd3;

  localparam logic [1:0] ALU_STYPE_AND = 2'd0;
  localparam logic [1:0] ALU_STYPE_OR  = 2'd1;
  localparam logic [1:0] ALU_STYPE_NOR = 2'd2;
  localparam logic [1:0] ALU_STYPE_XOR = 2'd3;

  localparam logic [1:0] ALU_STYPE_LUI       = 2'd0;
  localparam logic [1:0] ALU_STYPE_PCPLUS4   = 2'd1;
  localparam logic [1:0] ALU_STYPE_PCADDU12I = 2'd2;

  localparam logic [1:0] ALU_STYPE_ADD  = 2'd0;
  localparam logic [1:0] ALU_STYPE_SUB  = 2'd1;
  localparam logic [1:0] ALU_STYPE_SLT  = 2'd2;
  localparam logic [1:0] ALU_STYPE_SLTU = 2'd3;

  localparam logic [1:0] ALU_STYPE_SLL = 2'd0;
  localparam logic [1:0] ALU_STYPE_SRL = 2'd1;
  localparam logic [1:0] ALU_STYPE_SRA = 2'd2;

  typedef struct packed {
    logic [31:0]          r0;
    logic [31:0]          r1;
    logic [31:0]          pc;
    logic [1:0]           grand_op;
    logic [1:0]           op;
    logic [ALU_REG_W-1:0] rd;
    logic                 wen;
    logic [ALU_ROB_W-1:0] tag;
  } alu_req_t;

  typedef struct packed {
    logic [31:0]          res;
    logic [ALU_REG_W-1:0] rd;
    logic                 wen;
    logic [ALU_ROB_W-1:0] tag;
  } alu_res_t;

endpackage

// File: rtl/wired_alu_exe_alu.sv
// Combinational ALU: r1 is rj, r0 is rk/immediate; unused sub-op codes yield zero.
module wired_alu
  import wired_alu_exe_pkg::*;
(
  input  logic [31:0] i_r0,
  input  logic [31:0] i_r1,
  input  logic [31:0] i_pc,
  input  logic [1:0]  i_grand_op,
  input  logic [1:0]  i_op,
  output logic [31:0] o_res
);

  logic [4:0]  w_sh;
  logic [31:0] w_imm_u12;

  assign w_sh      = i_r0[4:0];
  assign w_imm_u12 = {i_r0[19:0], 12'h000};

  always_comb begin
    o_res = 32'h0;
    case (i_grand_op)
      ALU_GTYPE_BW: begin
        case (i_op)
          ALU_STYPE_AND: o_res = i_r1 & i_r0;
          ALU_STYPE_OR:  o_res = i_r1 | i_r0;
          ALU_STYPE_NOR: o_res = ~(i_r1 | i_r0);
          default:       o_res = i_r1 ^ i_r0;
        endcase
      end
      ALU_GTYPE_LI: begin
        case (i_op)
          ALU_STYPE_LUI:       o_res = w_imm_u12;
          ALU_STYPE_PCPLUS4:   o_res = i_pc + 32'd4;
          ALU_STYPE_PCADDU12I: o_res = i_pc + w_imm_u12;
          default:             o_res = 32'h0;
        endcase
      end
      ALU_GTYPE_INT: begin
        case (i_op)
          ALU_STYPE_ADD:  o_res = i_r1 + i_r0;
          ALU_STYPE_SUB:  o_res = i_r1 - i_r0;
          ALU_STYPE_SLT:  o_res = {31'h0, $signed(i_r1) < $signed(i_r0)};
          default:        o_res = {31'h0, i_r1 < i_r0};
        endcase
      end
      default: begin
        case (i_op)
          ALU_STYPE_SLL: o_res = i_r1 << w_sh;
          ALU_STYPE_SRL: o_res = i_r1 >> w_sh;
          ALU_STYPE_SRA: o_res = $unsigned($signed(i_r1) >>> w_sh);
          default:       o_res = 32'h0;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/wired_alu_exe.sv
// Two-stage ALU execute pipe: E1 holds registered operands, E2 holds the result for writeback.
module wired_alu_exe
  import wired_alu_exe_pkg::*;
#(
  parameter int ROB_W = ALU_ROB_W,
  parameter int REG_W = ALU_REG_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_r0_i,
  input  logic [31:0]      in_r1_i,
  input  logic [31:0]      in_pc_i,
  input  logic [1:0]       in_grand_op_i,
  input  logic [1:0]       in_op_i,
  input  logic [REG_W-1:0] in_rd_i,
  input  logic             in_wen_i,
  input  logic [ROB_W-1:0] in_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_res_o,
  output logic [REG_W-1:0] out_rd_o,
  output logic             out_wen_o,
  output logic [ROB_W-1:0] out_tag_o,
  output logic             byp_valid_o,
  output logic [REG_W-1:0] byp_rd_o,
  output logic [31:0]      byp_res_o
);

  logic       r_e1_valid;
  logic       r_e2_valid;
  alu_req_t   r_e1;
  alu_res_t   r_e2;

  alu_req_t    w_req;
  logic [31:0] w_alu_res;
  logic        w_e2_adv;
  logic        w_accept;
  logic        w_e1_move;

  assign w_req = '{
    r0:       in_r0_i,
    r1:       in_r1_i,
    pc:       in_pc_i,
    grand_op: in_grand_op_i,
    op:       in_op_i,
    rd:       in_rd_i,
    wen:      in_wen_i,
    tag:      in_tag_i
  };

  assign w_e2_adv   = ~r_e2_valid | out_ready_i;
  assign in_ready_o = ~r_e1_valid | w_e2_adv;
  assign w_accept   = in_valid_i & in_ready_o & ~flush_i;
  assign w_e1_move  = r_e1_valid & w_e2_adv;

  wired_alu u_alu (
    .i_r0       (r_e1.r0),
    .i_r1       (r_e1.r1),
    .i_pc       (r_e1.pc),
    .i_grand_op (r_e1.grand_op),
    .i_op       (r_e1.op),
    .o_res      (w_alu_res)
  );

  // Payload registers only load on a real transfer so E2 stays frozen under back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e1_valid <= 1'b0;
      r_e2_valid <= 1'b0;
      r_e1       <= '0;
      r_e2       <= '0;
    end else if (flush_i) begin
      r_e1_valid <= 1'b0;
      r_e2_valid <= 1'b0;
    end else begin
      if (w_e1_move) begin
        r_e2_valid <= 1'b1;
        r_e2       <= '{res: w_alu_res, rd: r_e1.rd, wen: r_e1.wen, tag: r_e1.tag};
      end else if (r_e2_valid && out_ready_i) begin
        r_e2_valid <= 1'b0;
      end

      if (w_accept) begin
        r_e1_valid <= 1'b1;
        r_e1       <= w_req;
      end else if (w_e1_move) begin
        r_e1_valid <= 1'b0;
      end
    end
  end

  assign out_valid_o = r_e2_valid;
  assign out_res_o   = r_e2.res;
  assign out_rd_o    = r_e2.rd;
  assign out_wen_o   = r_e2.wen;
  assign out_tag_o   = r_e2.tag;

  assign byp_valid_o = r_e2_valid & r_e2.wen;
  assign byp_rd_o    = r_e2.rd;
  assign byp_res_o   = r_e2.res;

endmodule

// File: tb/tb_wired_alu_exe.sv
// Self-checking bench for wired_alu_exe: vector table, directed pipeline corners, random scoreboard.
module tb_wired_alu_exe;
  import wired_alu_exe_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 flush_i;
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [31:0]          in_r0_i, in_r1_i, in_pc_i;
  logic [1:0]           in_grand_op_i, in_op_i;
  logic [ALU_REG_W-1:0] in_rd_i;
  logic                 in_wen_i;
  logic [ALU_ROB_W-1:0] in_tag_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [31:0]          out_res_o;
  logic [ALU_REG_W-1:0] out_rd_o;
  logic                 out_wen_o;
  logic [ALU_ROB_W-1:0] out_tag_o;
  logic                 byp_valid_o;
  logic [ALU_REG_W-1:0] byp_rd_o;
  logic [31:0]          byp_res_o;

  wired_alu_exe #(.ROB_W(ALU_ROB_W), .REG_W(ALU_REG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_r0_i(in_r0_i), .in_r1_i(in_r1_i), .in_pc_i(in_pc_i),
    .in_grand_op_i(in_grand_op_i), .in_op_i(in_op_i),
    .in_rd_i(in_rd_i), .in_wen_i(in_wen_i), .in_tag_i(in_tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_res_o(out_res_o), .out_rd_o(out_rd_o), .out_wen_o(out_wen_o), .out_tag_o(out_tag_o),
    .byp_valid_o(byp_valid_o), .byp_rd_o(byp_rd_o), .byp_res_o(byp_res_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] r1, input logic [31:0] r0,
                       input logic [31:0] pc, input logic [1:0] g, input logic [1:0] op,
                       input logic [ALU_REG_W-1:0] rd, input logic wen,
                       input logic [ALU_ROB_W-1:0] tag);
    in_valid_i = v; in_r1_i = r1; in_r0_i = r0; in_pc_i = pc;
    in_grand_op_i = g; in_op_i = op; in_rd_i = rd; in_wen_i = wen; in_tag_i = tag;
  endtask

  // Reference ALU computed from the instruction semantics with plain integer arithmetic.
  function automatic logic [31:0] ref_alu(input logic [31:0] r0, input logic [31:0] r1,
                                          input logic [31:0] pc, input logic [1:0] g,
                                          input logic [1:0] op);
    int          sh;
    int          s1, s0;
    logic [31:0] imm;
    sh  = int'(r0[4:0]);
    s1  = int'(r1);
    s0  = int'(r0);
    imm = 32'(r0[19:0]) * 32'd4096;
    case (g)
      ALU_GTYPE_BW:
        case (op)
          2'd0: return r1 & r0;
          2'd1: return r1 | r0;
          2'd2: return ~(r1 | r0);
          default: return r1 ^ r0;
        endcase
      ALU_GTYPE_LI:
        case (op)
          2'd0: return imm;
          2'd1: return pc + 32'd4;
          2'd2: return pc + imm;
          default: return 32'h0;
        endcase
      ALU_GTYPE_INT:
        case (op)
          2'd0: return 32'(longint'(r1) + longint'(r0));
          2'd1: return 32'(longint'(r1) - longint'(r0));
          2'd2: return (s1 < s0) ? 32'd1 : 32'd0;
          default: return (longint'(r1) < longint'(r0)) ? 32'd1 : 32'd0;
        endcase
      default:
        case (op)
          2'd0: return r1 << sh;
          2'd1: return r1 >> sh;
          2'd2: return 32'(s1 >>> sh);
          default: return 32'h0;
        endcase
    endcase
  endfunction

  typedef struct {
    string       name;
    logic [31:0] r1, r0, pc;
    logic [1:0]  g, op;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0]          res;
    logic [ALU_REG_W-1:0] rd;
    logic                 wen;
    logic [ALU_ROB_W-1:0] tag;
    int                   cyc;
  } exp_t;

  vec_t vecs[15];
  exp_t q[$];

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] s1, s2, s3, s4;
    logic [31:0] held;
    logic        exp_ov;
    exp_t        e;
    int          cyc;

    vecs[0]  = '{"add_ovf",   32'h7FFF_FFFF, 32'h1,         32'h0,         ALU_GTYPE_INT, ALU_STYPE_ADD,  32'h8000_0000};
    vecs[1]  = '{"sub",       32'h5,         32'h7,         32'h0,         ALU_GTYPE_INT, ALU_STYPE_SUB,  32'hFFFF_FFFE};
    vecs[2]  = '{"slt",       32'hFFFF_FFFF, 32'h1,         32'h0,         ALU_GTYPE_INT, ALU_STYPE_SLT,  32'h1};
    vecs[3]  = '{"sltu",      32'hFFFF_FFFF, 32'h1,         32'h0,         ALU_GTYPE_INT, ALU_STYPE_SLTU, 32'h0};
    vecs[4]  = '{"sra",       32'h8000_0000, 32'h4,         32'h0,         ALU_GTYPE_SFT, ALU_STYPE_SRA,  32'hF800_0000};
    vecs[5]  = '{"srl_sh5",   32'h8000_0000, 32'h24,        32'h0,         ALU_GTYPE_SFT, ALU_STYPE_SRL,  32'h0800_0000};
    vecs[6]  = '{"sll31",     32'h1,         32'd31,        32'h0,         ALU_GTYPE_SFT, ALU_STYPE_SLL,  32'h8000_0000};
    vecs[7]  = '{"pcaddu12i", 32'h0,         32'h1,         32'h1C00_0000, ALU_GTYPE_LI,  ALU_STYPE_PCADDU12I, 32'h1C00_1000};
    vecs[8]  = '{"pcplus4",   32'h0,         32'h0,         32'h1C00_0000, ALU_GTYPE_LI,  ALU_STYPE_PCPLUS4,   32'h1C00_0004};
    vecs[9]  = '{"lui",       32'h0,         32'hFFFA_BCDE, 32'h0,         ALU_GTYPE_LI,  ALU_STYPE_LUI,  32'hABCD_E000};
    vecs[10] = '{"and",       32'hF0F0_FFFF, 32'h0FF0_F00F, 32'h0,         ALU_GTYPE_BW,  ALU_STYPE_AND,  32'h00F0_F00F};
    vecs[11] = '{"or",        32'hF000_0000, 32'h0000_000F, 32'h0,         ALU_GTYPE_BW,  ALU_STYPE_OR,   32'hF000_000F};
    vecs[12] = '{"nor",       32'h0,         32'h0,         32'h0,         ALU_GTYPE_BW,  ALU_STYPE_NOR,  32'hFFFF_FFFF};
    vecs[13] = '{"xor",       32'hA5A5_A5A5, 32'hFFFF_0000, 32'h0,         ALU_GTYPE_BW,  ALU_STYPE_XOR,  32'h5A5A_A5A5};
    vecs[14] = '{"add_wrap",  32'hFFFF_FFFF, 32'h2,         32'h0,         ALU_GTYPE_INT, ALU_STYPE_ADD,  32'h1};

    rst_n = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
    drive(1'b0, '0, '0, '0, 2'd0, 2'd0, '0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid_o, 1'b0);
    check("rst_byp_valid", byp_valid_o, 1'b0);
    check("rst_out_res",   out_res_o, 32'h0);
    check("rst_out_tag",   out_tag_o, 6'h0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("rst_in_ready",  in_ready_o, 1'b1);

    // Single op through the pipe for each table entry: 2-cycle latency, 1-cycle pulse.
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].r1, vecs[i].r0, vecs[i].pc, vecs[i].g, vecs[i].op,
            5'(i), (i % 3) != 2, 6'(5 + i));
      check({vecs[i].name, "_in_ready"}, in_ready_o, 1'b1);
      tick();
      in_valid_i = 1'b0;
      check({vecs[i].name, "_e1_no_out"}, out_valid_o, 1'b0);
      tick();
      check({vecs[i].name, "_out_valid"}, out_valid_o, 1'b1);
      check({vecs[i].name, "_res"}, out_res_o, vecs[i].exp);
      check({vecs[i].name, "_tag"}, out_tag_o, 6'(5 + i));
      check({vecs[i].name, "_rd"},  out_rd_o, 5'(i));
      check({vecs[i].name, "_wen"}, out_wen_o, (i % 3) != 2);
      check({vecs[i].name, "_byp_valid"}, byp_valid_o, (i % 3) != 2);
      check({vecs[i].name, "_byp_res"}, byp_res_o, vecs[i].exp);
      check({vecs[i].name, "_byp_rd"},  byp_rd_o, 5'(i));
      tick();
      check({vecs[i].name, "_pulse_end"}, out_valid_o, 1'b0);
    end

    // Back-to-back stream, results on consecutive cycles.
    for (int k = 0; k < 7; k++) begin
      case (k)
        2: begin check("stream_v0", out_valid_o, 1'b1); check("stream_r0", out_res_o, 32'hFFFF_FFFE); end
        3: begin check("stream_v1", out_valid_o, 1'b1); check("stream_r1", out_res_o, 32'h1); end
        4: begin check("stream_v2", out_valid_o, 1'b1); check("stream_r2", out_res_o, 32'h0); end
        5: begin check("stream_v3", out_valid_o, 1'b1); check("stream_r3", out_res_o, 32'hF800_0000); end
        6: check("stream_end", out_valid_o, 1'b0);
        default: ;
      endcase
      case (k)
        0: drive(1'b1, 32'h5, 32'h7, 32'h0, ALU_GTYPE_INT, ALU_STYPE_SUB, 5'd1, 1'b1, 6'd10);
        1: drive(1'b1, 32'hFFFF_FFFF, 32'h1, 32'h0, ALU_GTYPE_INT, ALU_STYPE_SLT, 5'd2, 1'b1, 6'd11);
        2: drive(1'b1, 32'hFFFF_FFFF, 32'h1, 32'h0, ALU_GTYPE_INT, ALU_STYPE_SLTU, 5'd3, 1'b1, 6'd12);
        3: drive(1'b1, 32'h8000_0000, 32'h4, 32'h0, ALU_GTYPE_SFT, ALU_STYPE_SRA, 5'd4, 1'b1, 6'd13);
        default: in_valid_i = 1'b0;
      endcase
      tick();
    end

    // Back-pressure: three ops offered, two buffered, payload frozen, then drained in order.
    s1 = ref_alu(32'h3, 32'h10, 32'h0, ALU_GTYPE_INT, ALU_STYPE_ADD);
    s2 = ref_alu(32'h3, 32'h10, 32'h0, ALU_GTYPE_INT, ALU_STYPE_SUB);
    s3 = ref_alu(32'h3, 32'h10, 32'h0, ALU_GTYPE_SFT, ALU_STYPE_SLL);
    out_ready_i = 1'b0;
    drive(1'b1, 32'h10, 32'h3, 32'h0, ALU_GTYPE_INT, ALU_STYPE_ADD, 5'd7, 1'b1, 6'd20);
    check("bp_rdy0", in_ready_o, 1'b1);
    tick();
    drive(1'b1, 32'h10, 32'h3, 32'h0, ALU_GTYPE_INT, ALU_STYPE_SUB, 5'd8, 1'b1, 6'd21);
    check("bp_rdy1", in_ready_o, 1'b1);
    tick();
    drive(1'b1, 32'h10, 32'h3, 32'h0, ALU_GTYPE_SFT, ALU_STYPE_SLL, 5'd9, 1'b1, 6'd22);
    for (int k = 0; k < 3; k++) begin
      check("bp_full_rdy", in_ready_o, 1'b0);
      check("bp_hold_valid", out_valid_o, 1'b1);
      check("bp_hold_res", out_res_o, s1);
      check("bp_hold_tag", out_tag_o, 6'd20);
      tick();
    end
    out_ready_i = 1'b1;
    #1;
    check("bp_release_rdy", in_ready_o, 1'b1);
    check("bp_out0", out_res_o, s1);
    tick();
    in_valid_i = 1'b0;
    check("bp_v1", out_valid_o, 1'b1);
    check("bp_out1", out_res_o, s2);
    check("bp_tag1", out_tag_o, 6'd21);
    tick();
    check("bp_v2", out_valid_o, 1'b1);
    check("bp_out2", out_res_o, s3);
    check("bp_tag2", out_tag_o, 6'd22);
    tick();
    check("bp_drained", out_valid_o, 1'b0);

    // Flush with a full pipe; the op presented during flush must be dropped.
    out_ready_i = 1'b0;
    drive(1'b1, 32'h1, 32'h1, 32'h0, ALU_GTYPE_INT, ALU_STYPE_ADD, 5'd1, 1'b1, 6'd30);
    tick();
    drive(1'b1, 32'h2, 32'h2, 32'h0, ALU_GTYPE_INT, ALU_STYPE_ADD, 5'd2, 1'b1, 6'd31);
    tick();
    check("fl_full", out_valid_o, 1'b1);
    check("fl_full_rdy", in_ready_o, 1'b0);
    out_ready_i = 1'b1;
    flush_i = 1'b1;
    drive(1'b1, 32'h9, 32'h9, 32'h0, ALU_GTYPE_INT, ALU_STYPE_ADD, 5'd3, 1'b1, 6'd32);
    tick();
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    check("fl_out_valid", out_valid_o, 1'b0);
    check("fl_byp_valid", byp_valid_o, 1'b0);
    tick();
    check("fl_dropped", out_valid_o, 1'b0);
    s4 = 32'h1234_5000;
    drive(1'b1, 32'h0, 32'h0001_2345, 32'h0, ALU_GTYPE_LI, ALU_STYPE_LUI, 5'd4, 1'b1, 6'd33);
    tick();
    in_valid_i = 1'b0;
    check("fl_fresh_e1", out_valid_o, 1'b0);
    tick();
    check("fl_fresh_valid", out_valid_o, 1'b1);
    check("fl_fresh_res", out_res_o, s4);
    check("fl_fresh_tag", out_tag_o, 6'd33);
    tick();

    // Asynchronous reset between edges with a full pipe.
    out_ready_i = 1'b0;
    drive(1'b1, 32'h4, 32'h4, 32'h0, ALU_GTYPE_INT, ALU_STYPE_ADD, 5'd5, 1'b1, 6'd40);
    tick();
    drive(1'b1, 32'h5, 32'h5, 32'h0, ALU_GTYPE_INT, ALU_STYPE_ADD, 5'd6, 1'b1, 6'd41);
    tick();
    in_valid_i = 1'b0;
    check("ar_pre_valid", out_valid_o, 1'b1);
    check("ar_pre_byp", byp_valid_o, 1'b1);
    held = out_res_o;
    check("ar_pre_res", held, 32'h8);
    #2 rst_n = 1'b0;
    #1;
    check("ar_out_valid", out_valid_o, 1'b0);
    check("ar_byp_valid", byp_valid_o, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    out_ready_i = 1'b1;
    tick();
    check("ar_in_ready", in_ready_o, 1'b1);
    check("ar_no_out", out_valid_o, 1'b0);
    tick();
    check("ar_no_partial", out_valid_o, 1'b0);

    // Random traffic against a queue-based scoreboard.
    cyc = 0;
    for (int it = 0; it < 3000; it++) begin
      @(negedge clk);
      in_valid_i    = ($urandom_range(0, 3) != 0);
      out_ready_i   = ($urandom_range(0, 3) != 0);
      flush_i       = ($urandom_range(0, 39) == 0);
      in_r0_i       = rnd_word();
      in_r1_i       = rnd_word();
      in_pc_i       = $urandom;
      in_grand_op_i = 2'($urandom_range(0, 3));
      in_op_i       = 2'($urandom_range(0, 3));
      in_rd_i       = 5'($urandom);
      in_wen_i      = 1'($urandom);
      in_tag_i      = 6'($urandom);
      #1;
      check("rnd_in_ready", in_ready_o, (q.size() < 2) || out_ready_i);
      exp_ov = (q.size() > 0) && (cyc - q[0].cyc >= 2);
      check("rnd_out_valid", out_valid_o, exp_ov);
      if (exp_ov)
        check("rnd_byp_valid", byp_valid_o, q[0].wen);
      if (out_valid_o && out_ready_i && q.size() > 0) begin
        e = q.pop_front();
        check("rnd_res", out_res_o, e.res);
        check("rnd_rd",  out_rd_o,  e.rd);
        check("rnd_wen", out_wen_o, e.wen);
        check("rnd_tag", out_tag_o, e.tag);
      end
      if (flush_i)
        q.delete();
      else if (in_valid_i && in_ready_o)
        q.push_back('{ref_alu(in_r0_i, in_r1_i, in_pc_i, in_grand_op_i, in_op_i),
                      in_rd_i, in_wen_i, in_tag_i, cyc});
      cyc++;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
